// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the LEGv8 pipeline datapath (master) and
// the hazard unit (slave): ID-stage operand info, branch resolution,
// counter clear, and the stall/flush/forward controls back to the pipe.
interface pipe_hazard_ctrl_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
);
  logic                valid_D;
  logic [REG_BITS-1:0] rs1_D;
  logic [REG_BITS-1:0] rs2_D;
  logic                use1_D;
  logic                use2_D;
  logic [REG_BITS-1:0] wa_D;
  logic                regWrite_D;
  logic                memRead_D;
  logic                pcsrc_M;
  logic                cnt_clr;
  logic                stall_F;
  logic                stall_D;
  logic                flush_D;
  logic                flush_E;
  logic                flush_M;
  logic [1:0]          fwdA_E;
  logic [1:0]          fwdB_E;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output valid_D, rs1_D, rs2_D, use1_D, use2_D, wa_D, regWrite_D, memRead_D,
    output pcsrc_M, cnt_clr,
    input  stall_F, stall_D, flush_D, flush_E, flush_M, fwdA_E, fwdB_E,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_D, rs1_D, rs2_D, use1_D, use2_D, wa_D, regWrite_D, memRead_D,
    input  pcsrc_M, cnt_clr,
    output stall_F, stall_D, flush_D, flush_E, flush_M, fwdA_E, fwdB_E,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard-control unit for the 5-stage LEGv8 pipeline. Tracks the destination
// registers of the instructions in EX/MEM/WB in a small shadow pipeline,
// raises stall for RAW / load-use hazards against the ID instruction, flushes
// wrong-path work on a taken branch in MEM, selects EX forwarding sources and
// keeps saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int REG_BITS  = 5,
  parameter int ZERO_REG  = 31,
  parameter bit FWD_EN    = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] wa;
    logic                rw;
    logic                mr;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic                u1;
    logic                u2;
  } entry_t;

  localparam logic [REG_BITS-1:0] ZeroIdx = REG_BITS'(ZERO_REG);
  localparam logic [CNT_W-1:0]    CntMax  = '1;

  // A source only depends on an older instruction that really writes it;
  // XZR never carries a dependency.
  function automatic logic match(input entry_t x, input logic [REG_BITS-1:0] rs, input logic u);
    return u && (rs != ZeroIdx) && x.v && x.rw && (x.wa == rs);
  endfunction

  entry_t           eReg, mReg, wReg;
  entry_t           eNext, mNext, wNext;
  entry_t           idEntry;
  logic             hzdE, hzdM, hzdW;
  logic             stall;
  logic             stallOut;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stallCntReg, flushCntReg;

  assign idEntry = '{v: hz.valid_D, wa: hz.wa_D, rw: hz.regWrite_D, mr: hz.memRead_D,
                     rs1: hz.rs1_D, rs2: hz.rs2_D, u1: hz.use1_D, u2: hz.use2_D};

  // Dependencies of the ID instruction on each in-flight stage.
  always_comb begin
    hzdE = hz.valid_D && (match(eReg, hz.rs1_D, hz.use1_D) || match(eReg, hz.rs2_D, hz.use2_D));
    hzdM = hz.valid_D && (match(mReg, hz.rs1_D, hz.use1_D) || match(mReg, hz.rs2_D, hz.use2_D));
    hzdW = hz.valid_D && (match(wReg, hz.rs1_D, hz.use1_D) || match(wReg, hz.rs2_D, hz.use2_D));
  end

  // With forwarding only a load in EX is too late; without it any older
  // writer still in flight blocks ID. WB blocks unless the regfile bypasses.
  always_comb begin
    stall = 1'b0;
    if (FWD_EN) begin
      stall = hzdE && eReg.mr;
    end else begin
      stall = hzdE || hzdM;
    end
    if (!WB_BYPASS && hzdW) begin
      stall = 1'b1;
    end
  end

  // A taken branch kills the younger work, so it overrides the stall.
  assign stallOut   = stall && !hz.pcsrc_M;
  assign hz.stall_F = stallOut;
  assign hz.stall_D = stallOut;
  assign hz.flush_D = hz.pcsrc_M;
  assign hz.flush_E = hz.pcsrc_M;
  assign hz.flush_M = hz.pcsrc_M;

  // Shadow pipeline advance: bubbles enter where the real pipe is flushed
  // or where ID is held back.
  always_comb begin
    wNext = mReg;
    mNext = eReg;
    eNext = idEntry;
    if (hz.pcsrc_M) begin
      mNext = '0;
      eNext = '0;
    end else if (stall) begin
      eNext = '0;
    end
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eReg <= '0;
      mReg <= '0;
      wReg <= '0;
    end else begin
      eReg <= eNext;
      mReg <= mNext;
      wReg <= wNext;
    end
  end

  // Operand source for the instruction in EX; the younger MEM result wins.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (FWD_EN && eReg.v) begin
      if (match(mReg, eReg.rs1, eReg.u1)) begin
        fwdA = 2'b10;
      end else if (match(wReg, eReg.rs1, eReg.u1)) begin
        fwdA = 2'b01;
      end
      if (match(mReg, eReg.rs2, eReg.u2)) begin
        fwdB = 2'b10;
      end else if (match(wReg, eReg.rs2, eReg.u2)) begin
        fwdB = 2'b01;
      end
    end
  end

  assign hz.fwdA_E = fwdA;
  assign hz.fwdB_E = fwdB;

  // Saturating count of cycles in which fetch/decode were held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntReg <= '0;
    end else if (hz.cnt_clr) begin
      stallCntReg <= '0;
    end else if (stallOut && (stallCntReg != CntMax)) begin
      stallCntReg <= stallCntReg + CNT_W'(1);
    end
  end

  // Saturating count of cycles in which a taken branch flushed the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flushCntReg <= '0;
    end else if (hz.cnt_clr) begin
      flushCntReg <= '0;
    end else if (hz.pcsrc_M && (flushCntReg != CntMax)) begin
      flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stallCntReg;
  assign hz.flush_cnt = flushCntReg;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard-control unit for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB) that drives its stall, flush and forwarding controls. It keeps its own shadow pipeline of in-flight destination registers for EX, MEM and WB, and detects RAW and load-use hazards against the instruction in ID. It also flushes wrong-path instructions when a branch resolves taken in MEM, and counts stall and flush cycles. A parameter selects full forwarding or the stall-only mode that the current no-forwarding datapath needs.

Parameters:
REG_BITS, 5, register-index width
ZERO_REG, 31, register index that never creates a hazard (XZR)
FWD_EN, 1, 1 = forward from MEM/WB and stall only on load-use; 0 = stall on any RAW, fwd outputs held 00
WB_BYPASS, 1, 1 = register file writes before it reads in the same cycle; 0 = a match between ID and the WB stage also stalls
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low (0 = reset)
valid_D  in  1  ID holds a real instruction
rs1_D, rs2_D  in  REG_BITS  ID source register indices
use1_D, use2_D  in  1  ID actually reads rs1/rs2
wa_D  in  REG_BITS  ID destination register
regWrite_D, memRead_D  in  1  ID control bits
pcsrc_M  in  1  branch taken, resolved in MEM
cnt_clr  in  1  synchronous clear of both counters
stall_F, stall_D  out  1  hold the PC and IF/ID
flush_D, flush_E, flush_M  out  1  zero the IF/ID, ID/EX and EX/MEM registers
fwdA_E, fwdB_E  out  2  EX operand select: 00 = register file, 10 = MEM ALU result, 01 = WB result
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Shadow entries E, M and W each hold {v, wa, rw, mr, rs1, rs2, u1, u2}. On reset, every field is 0 and both counters are 0.
- With all entries invalid after reset, every output is 0 and the fwd outputs are 00.
- match(X, rs, u) is true when all of these hold: u=1, rs != ZERO_REG, X.v=1, X.rw=1, X.wa=rs.
- hzd(X) = valid_D and (match(X, rs1_D, use1_D) or match(X, rs2_D, use2_D)).
- Stall condition, FWD_EN=1: stall = hzd(E) and E.mr. This is the load-use case only.
- Stall condition, FWD_EN=0: stall = hzd(E) or hzd(M), or hzd(W) when WB_BYPASS=0.
- Stall condition, FWD_EN=1 and WB_BYPASS=0: hzd(W) also stalls.
- Flush: flush_D = flush_E = flush_M = pcsrc_M.
- Stall outputs: stall_F = stall_D = stall and not pcsrc_M. Flush has priority over stall.
- Shadow update when pcsrc_M=1: W<=M, M<=bubble, E<=bubble. A bubble has v=0.
- Shadow update when stall=1 (and no flush): W<=M, M<=E, E<=bubble. The ID instruction is held and re-evaluated next cycle.
- Shadow update otherwise: W<=M, M<=E, E<={valid_D, wa_D, regWrite_D, memRead_D, rs1_D, rs2_D, use1_D, use2_D}.
- Forwarding (combinational from the entries, FWD_EN=1): fwdA_E = 10 if E.v and match(M, E.rs1, E.u1); else 01 if E.v and match(W, E.rs1, E.u1); else 00. The MEM stage wins over WB. fwdB_E uses rs2/u2 the same way.
- Forwarding with FWD_EN=0: fwdA_E and fwdB_E are always 00.
- Latency: stall and flush are combinational in the same cycle as their cause. A load-use stall lasts exactly 1 cycle with FWD_EN=1. A dependency on E lasts up to 3 cycles with FWD_EN=0 and WB_BYPASS=0.
- Counters: stall_cnt increments on each cycle with stall_F=1; flush_cnt increments on each cycle with pcsrc_M=1. Both saturate at all-ones with no wrap. cnt_clr has priority over increment.
- Reset asserted mid-operation immediately clears all entries and counters; outputs drop to 0 asynchronously.

Test Plan:
- Reset, then idle with valid_D=0 -> all outputs 0 and counters 0; asserting reset mid-stall drops stall_F within the same cycle.
- FWD_EN=1: ADD X1 in ID, then SUB reading X1 next cycle -> no stall; fwdA_E=10 in SUB's EX cycle; with one unrelated instruction in between, fwdA_E=01.
- FWD_EN=1: LDUR X2 followed by ADD reading X2 -> stall_F=stall_D=1 for exactly 1 cycle, stall_cnt=1; fwdA_E=01 on the ADD's EX cycle.
- Producer writes X31 (XZR) and the consumer reads X31 -> no stall and fwd=00 in both modes.
- FWD_EN=0, WB_BYPASS=0: ADD X3 followed by a reader of X3 -> 3 stall cycles, stall_cnt=3; with WB_BYPASS=1 -> 2 stall cycles.
- Load-use stall in the same cycle as pcsrc_M=1 -> stall_F=0, all flush outputs=1, E and M become bubbles, flush_cnt=1; 2^CNT_W+1 stall cycles with CNT_W=4 -> stall_cnt saturates at 15.
